// File: rtl/ibex_pkg.sv
// Shared definitions for the CHERI tag-memory responder.
//   CapGranuleBytes : bytes covered by one capability tag bit
//   cheri_pend_t    : pending-response entry {local_err, tag}
package ibex_pkg;

  localparam int unsigned CapGranuleBytes = 8;

  typedef struct packed {
    logic local_err;  // response generated locally (out-of-range / rejected)
    logic tag;        // granule tag captured at grant
  } cheri_pend_t;

endpackage

// File: rtl/ibex_cheri_resp_fifo.sv
// Pending-response FIFO for the CHERI tag-memory responder.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   push_i, data_i  : write an entry (ignored when full)
//   pop_i, data_o   : drop the head entry (ignored when empty); data_o is the head
//   full_o, empty_o : occupancy flags, based on the registered count
module ibex_cheri_resp_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  cheri_pend_t data_i,
  input  logic        pop_i,
  output cheri_pend_t data_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  cheri_pend_t     mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            push_en;
  logic            pop_en;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_en) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_en, pop_en})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ibex_cheri_tag_mem_resp.sv
// Memory-side responder for the CHERI data interface. Sits between the LSU
// data port and an untagged RAM, keeps one tag bit per 8-byte granule,
// forwards in-range requests to the RAM and answers out-of-range requests
// locally with an error. Responses return strictly in request order.
// Ports:
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   data_*                    : core-side request/grant/response channel
//   mem_*                     : RAM-side request/grant/response channel
// Optional feature: define IBEX_CHERI_CAP_ALIGN_CHECK_EN to reject capability
// beats with partial byte enables (answered locally with an error).
module ibex_cheri_tag_mem_resp
  import ibex_pkg::*;
#(
  parameter logic [31:0] MemBase        = 32'h0010_0000,
  parameter logic [31:0] MemSize        = 32'h0000_1000,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  input  logic        data_cap_i,
  input  logic        data_wtag_i,
  output logic [31:0] data_rdata_o,
  output logic        data_rtag_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  localparam int unsigned NumTags = MemSize / CapGranuleBytes;
  localparam int unsigned OffW    = $clog2(MemSize);
  localparam int unsigned IdxW    = (NumTags > 1) ? $clog2(NumTags) : 1;

  // 33-bit bounds so a region ending at 4 GiB cannot wrap.
  localparam logic [32:0] BaseExt  = {1'b0, MemBase};
  localparam logic [32:0] LimitExt = {1'b0, MemBase} + {1'b0, MemSize};

  logic [NumTags-1:0] tags_q;
  logic [IdxW-1:0]    tag_idx;
  logic [32:0]        addr_ext;
  logic               in_range;
  logic               cap_misaligned;
  logic               fwd;
  logic               can_issue;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  cheri_pend_t        push_entry;
  cheri_pend_t        head;

  assign addr_ext = {1'b0, data_addr_i};
  assign in_range = (addr_ext >= BaseExt) && (addr_ext < LimitExt);

  // Only the offset bits inside the region matter; MemBase is granule
  // aligned, so subtracting just those bits cannot borrow from below.
  if (NumTags > 1) begin : g_idx
    assign tag_idx = data_addr_i[OffW-1:3] - MemBase[OffW-1:3];
  end else begin : g_idx_single
    assign tag_idx = '0;
  end

`ifdef IBEX_CHERI_CAP_ALIGN_CHECK_EN
  assign cap_misaligned = data_cap_i & (data_be_i != 4'hF);
`else
  assign cap_misaligned = 1'b0;
`endif

  assign fwd = in_range & ~cap_misaligned;

  // rst_ni gates the request side so nothing is granted while in reset.
  assign can_issue  = rst_ni & data_req_i & ~fifo_full;
  assign mem_req_o  = can_issue & fwd;
  // Local answers only when nothing is in flight, which keeps them ordered
  // behind RAM responses and avoids two responses in one cycle.
  assign data_gnt_o = fwd ? (mem_req_o & mem_gnt_i) : (can_issue & fifo_empty);

  assign mem_addr_o  = data_addr_i;
  assign mem_we_o    = data_we_i;
  assign mem_be_o    = data_be_i;
  assign mem_wdata_o = data_wdata_i;

  always_comb begin
    push_entry           = '0;
    push_entry.local_err = ~fwd;
    push_entry.tag       = fwd & tags_q[tag_idx];
  end

  // Non-capability writes of any width destroy the granule's tag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tags_q <= '0;
    end else if (data_gnt_o && fwd && data_we_i) begin
      tags_q[tag_idx] <= data_cap_i & data_wtag_i;
    end
  end

  ibex_cheri_resp_fifo #(
    .Depth (MaxOutstanding)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (data_gnt_o),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign fifo_pop      = ~fifo_empty & (head.local_err | mem_rvalid_i);
  assign data_rvalid_o = fifo_pop;
  assign data_err_o    = fifo_pop & (head.local_err | mem_err_i);
  assign data_rdata_o  = (fifo_pop & ~head.local_err) ? mem_rdata_i : '0;
  assign data_rtag_o   = fifo_pop & ~head.local_err & head.tag & ~mem_err_i;

  // A RAM response must always match a forwarded request at the FIFO head.
  mem_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> (!fifo_empty && !head.local_err));

endmodule

// File: doc/ibex_cheri_tag_mem_resp.md
Name: ibex_cheri_tag_mem_resp

Overview:
- Memory-side responder for the CHERI data interface; sits between the core LSU data port and a plain untagged data RAM.
- Keeps one tag bit per 8-byte capability granule in internal flops.
- Forwards in-range requests to the RAM and returns the granule tag with every response.
- Answers out-of-range requests locally with an error, in order, using a small pending-response FIFO.

Parameters:
MemBase, 32'h0010_0000, byte base address of the tagged region (8-byte aligned)
MemSize, 32'h0000_1000, region size in bytes (power of two, >=8); NumTags = MemSize/8
MaxOutstanding, 2, pending-response FIFO depth (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
data_req_i  in  1  core request
data_gnt_o  out  1  grant to core
data_rvalid_o  out  1  response valid
data_addr_i  in  32  word-aligned address
data_we_i  in  1  write
data_be_i  in  4  byte enables
data_wdata_i  in  32  write data
data_cap_i  in  1  beat belongs to a capability access
data_wtag_i  in  1  tag of capability being stored
data_rdata_o  out  32  read data
data_rtag_o  out  1  tag of addressed granule, sampled at grant
data_err_o  out  1  error response
mem_req_o  out  1  RAM request
mem_gnt_i  in  1  RAM grant
mem_addr_o  out  32  = data_addr_i
mem_we_o  out  1  = data_we_i
mem_be_o  out  4  = data_be_i
mem_wdata_o  out  32  = data_wdata_i
mem_rvalid_i  in  1  RAM response (latency >=1 after grant)
mem_rdata_i  in  32  RAM read data
mem_err_i  in  1  RAM error

Behaviour:
- in_range = data_addr_i in [MemBase, MemBase+MemSize), using 33-bit compare, no wrap.
- tag_idx = (data_addr_i - MemBase)[log2(MemSize)-1:3].
- FIFO full or reset: data_gnt_o=0, mem_req_o=0.
- In-range request:
  - mem_req_o = data_req_i & ~full.
  - data_gnt_o = mem_req_o & mem_gnt_i.
  - On grant, push {local=0, tag=tags[tag_idx]} (pre-write value).
- Out-of-range request:
  - Not forwarded; mem_req_o=0.
  - data_gnt_o=1 only when FIFO empty.
  - Push {local=1, tag=0}.
  - The empty-FIFO rule guarantees in-order responses without collision.
- Tag update happens on a granted in-range write only, in the grant cycle:
  - data_cap_i=1: tags[tag_idx] <= data_wtag_i (both beats).
  - data_cap_i=0: tags[tag_idx] <= 0 regardless of data_be_i.
  - A read granted the cycle after a write sees the updated tag.
- Response pops the FIFO head:
  - local=1 head: pops in the first cycle it is head. data_rvalid_o=1, data_err_o=1, data_rdata_o=0, data_rtag_o=0.
  - local=0 head: pops on mem_rvalid_i. data_rvalid_o=1, data_rdata_o=mem_rdata_i, data_err_o=mem_err_i, data_rtag_o = head tag & ~mem_err_i.
  - mem_rvalid_i with empty FIFO or local head: protocol violation, assertion.
- Simultaneous push and pop in the same cycle: allowed; occupancy unchanged; full is evaluated on the pre-update count.
- Pointers wrap modulo MaxOutstanding; count width is $clog2(MaxOutstanding+1).
- Reset, including mid-operation: all tags 0, FIFO empty, data_gnt_o/data_rvalid_o/data_err_o/data_rtag_o=0, data_rdata_o=0, mem_req_o=0. Outstanding RAM responses after reset are discarded.

Optional Feature:
Macro IBEX_CHERI_CAP_ALIGN_CHECK_EN.
- Defined: a request with data_cap_i=1 and data_be_i!=4'hF is treated as out-of-range: local error, not forwarded, no tag change.
- Undefined: no alignment check; behaviour as above.

Decomposition:
- Shared package (ibex_pkg): CapGranuleBytes=8 constant and the pending-entry struct {logic local_err; logic tag;}.
- One sub-module: ibex_cheri_resp_fifo, a parameterised synchronous FIFO with full/empty flags and async active-low reset.
- Tag array and range logic stay in the top module.

Test Plan:
- Cap store to 0x0010_0008 then 0x0010_000C with data_cap_i=1, data_wtag_i=1; then load 0x0010_0008 -> data_rtag_o=1, data_err_o=0, data_rdata_o equals stored word.
- Byte store data_be_i=4'b0010, data_cap_i=0 to 0x0010_000C after the above; load 0x0010_0008 -> data_rtag_o=0.
- Load 0x0000_0000 with FIFO empty -> no mem_req_o, data_rvalid_o next cycle with data_err_o=1, data_rtag_o=0.
- Out-of-range request issued while one RAM read is pending -> data_gnt_o held 0 until that response pops, then granted; responses arrive in order.
- MaxOutstanding=2, RAM latency 4, three back-to-back loads -> third grant stalled until first response; mem_err_i=1 on second -> data_err_o=1, data_rtag_o=0.
- Tagged cap store, assert rst_ni mid-burst, release, load same granule -> data_rtag_o=0, no stale data_rvalid_o.
